// File: rtl/add16_pkg.sv
// add16_pkg: shared widths and word type for the add16_reg adder slice.
package add16_pkg;

    localparam int unsigned ADD16_W     = 16;
    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned NUM_NIBBLES = ADD16_W / NIBBLE_W;

    typedef logic [ADD16_W-1:0] add16_word_t;

endpackage : add16_pkg

// File: rtl/add16_reg_nibble_add4.sv
// nibble_add4: 4-bit ripple-carry adder built from four full-adder cells.
// c3 is the carry into bit 3, exported so the top can form signed overflow.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [4:0] carry;

    // Full-adder cells chained from bit 0 to bit 3.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co = carry[4];
    assign c3 = carry[3];

endmodule : nibble_add4

// File: rtl/add16_reg.sv
// add16_reg: 16-bit ripple-carry adder (a + b + c_in) with a one-cycle
// registered result. Four nibble_add4 stages form the carry chain.
// Optional feature: define ADD16_REG_OVF_EN to add the registered signed
// overflow output ovf.
module add16_reg
    import add16_pkg::*;
#(
    parameter int unsigned DATA_W = ADD16_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] sum,
    output logic              c_out
`ifdef ADD16_REG_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int unsigned NUM_NIB = DATA_W / NIBBLE_W;

    logic [NUM_NIB:0]   nib_c;
    logic [NUM_NIB-1:0] nib_c3;
    logic [DATA_W-1:0]  sum_c;

    logic [DATA_W-1:0]  sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               out_valid_q, out_valid_d;

    assign nib_c[0] = c_in;

    // Ripple chain: nibble k consumes the carry produced by nibble k-1.
    for (genvar k = 0; k < NUM_NIB; k++) begin : g_nib
        nibble_add4 u_nib (
            .a  (a[k*NIBBLE_W +: NIBBLE_W]),
            .b  (b[k*NIBBLE_W +: NIBBLE_W]),
            .ci (nib_c[k]),
            .s  (sum_c[k*NIBBLE_W +: NIBBLE_W]),
            .co (nib_c[k+1]),
            .c3 (nib_c3[k])
        );
    end

`ifdef ADD16_REG_OVF_EN
    logic ovf_q, ovf_d;
    logic unused_c3;
    // Only the MSB nibble's carry-into-bit-3 matters for signed overflow.
    assign unused_c3 = ^nib_c3[NUM_NIB-2:0];
`else
    logic unused_c3;
    assign unused_c3 = ^nib_c3;
`endif

    // Next-state: capture a new result on valid, otherwise hold (blocks X on idle operands).
    always_comb begin
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = 1'b0;
`ifdef ADD16_REG_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (in_valid) begin
            sum_d       = sum_c;
            c_out_d     = nib_c[NUM_NIB];
            out_valid_d = 1'b1;
`ifdef ADD16_REG_OVF_EN
            ovf_d       = nib_c3[NUM_NIB-1] ^ nib_c[NUM_NIB];
`endif
        end
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ADD16_REG_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
`ifdef ADD16_REG_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign out_valid = out_valid_q;
`ifdef ADD16_REG_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule : add16_reg

// File: tb/tb_add16_reg.sv
// tb_add16_reg: scoreboard bench for add16_reg. Expected results are pushed
// when operands are driven and popped when out_valid is seen.
module tb_add16_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        out_valid;
    logic [15:0] sum;
    logic        c_out;
`ifdef ADD16_REG_OVF_EN
    logic        ovf;
`endif

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;

    int unsigned n_checks;
    int unsigned n_fail;

    add16_reg u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .sum       (sum),
        .c_out     (c_out)
`ifdef ADD16_REG_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_sum"}, 32'(sum), 32'(held.s));
        check_eq({tag, "_cout"}, 32'(c_out), 32'(held.c));
`ifdef ADD16_REG_OVF_EN
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(held.o));
`endif
    endtask

    // Drive one operand set (or an idle cycle), then check after the edge.
    task automatic step(input string tag, input logic v, input logic [15:0] ia,
                        input logic [15:0] ib, input logic ic);
        logic [16:0] full;
        exp_t        e;
        in_valid = v;
        a        = ia;
        b        = ib;
        c_in     = ic;
        if (v) begin
            full = 17'(ia) + 17'(ib) + 17'(ic);
            e.s  = full[15:0];
            e.c  = full[16];
            e.o  = (ia[15] == ib[15]) && (full[15] != ia[15]);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            end else begin
                held = exp_q.pop_front();
            end
        end
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        held     = '{s: 16'h0, c: 1'b0, o: 1'b0};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases.
        step("zero",    1'b1, 16'h0000, 16'h0000, 1'b0);
        step("cin",     1'b1, 16'h0005, 16'h0003, 1'b1);
        step("prop",    1'b1, 16'hFFFF, 16'h0001, 1'b0);
        step("sovf",    1'b1, 16'h7FFF, 16'h0001, 1'b0);
        step("wrap1",   1'b1, 16'hFFFF, 16'h0000, 1'b1);
        step("wrap2",   1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        step("negovf",  1'b1, 16'h8000, 16'h8000, 1'b0);

        // Sweep: a bumps every cycle, b every 5 cycles; crosses the 16-bit wrap.
        begin
            logic [15:0] sa;
            logic [15:0] sb;
            sa = 16'hFF00;
            sb = 16'hFF80;
            for (int i = 0; i < 500; i++) begin
                step("sweep", 1'b1, sa, sb, 1'b0);
                sa = sa + 16'd1;
                if ((i % 5) == 4) sb = sb + 16'd1;
            end
        end

        // Hold: load one result, then idle with X operands; outputs must not move.
        step("load",  1'b1, 16'h1234, 16'h1111, 1'b0);
        check_eq("load_val", 32'(sum), 32'h2345);
        step("hold1", 1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
        step("hold2", 1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
        check_eq("hold_val", 32'(sum), 32'h2345);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        held = '{s: 16'h0, c: 1'b0, o: 1'b0};
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, 16'hABCD, 16'h1234, 1'b1);
        step("idle_end", 1'b0, 16'h0000, 16'h0000, 1'b0);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_add16_reg
